// File: rtl/input_event_unit.sv
// Debounced button/rotary event unit: a pending mask of press events with fixed-priority presentation, ack and overrun.
// Rotary decode is compiled in only when INPUT_EVENT_ROTARY_EN is defined.

module input_event_debounce #(
    parameter logic [15:0] LIMIT = 16'd4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic        sync_a;
    logic        sync_b;
    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            count  <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == LIMIT - 16'd1) begin
                level <= ~level;
                count <= '0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

module input_event_unit #(
    parameter logic [15:0] DEBOUNCE_CYCLES     = 16'd50000,
    parameter logic [15:0] ROT_DEBOUNCE_CYCLES = 16'd500
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_CNTR,
    input  logic       ROT_A,
    input  logic       ROT_B,
    input  logic       iAck,
    output logic [4:0] oBTN,
    output logic [2:0] oEvent,
    output logic       oValid,
    output logic       oOverrun
);

    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_prev;
    logic [6:0] set_mask;
    logic [6:0] ack_mask;
    logic [6:0] lowest;
    logic [6:0] pending;
    logic       overrun;
    logic [2:0] code;

    assign btn_raw = {BTN_CNTR, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        input_event_debounce #(
            .LIMIT(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (Clock),
            .rst_n(Reset),
            .raw  (btn_raw[i]),
            .level(btn_level[i])
        );
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) btn_prev <= '0;
        else        btn_prev <= btn_level;
    end

`ifdef INPUT_EVENT_ROTARY_EN
    logic rot_a_level;
    logic rot_b_level;
    logic rot_a_prev;
    logic rot_rise;

    input_event_debounce #(
        .LIMIT(ROT_DEBOUNCE_CYCLES)
    ) u_rot_a (
        .clk  (Clock),
        .rst_n(Reset),
        .raw  (ROT_A),
        .level(rot_a_level)
    );

    input_event_debounce #(
        .LIMIT(ROT_DEBOUNCE_CYCLES)
    ) u_rot_b (
        .clk  (Clock),
        .rst_n(Reset),
        .raw  (ROT_B),
        .level(rot_b_level)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) rot_a_prev <= 1'b0;
        else        rot_a_prev <= rot_a_level;
    end

    assign rot_rise = rot_a_level & ~rot_a_prev;
`else
    logic unused_rot;
    assign unused_rot = ROT_A ^ ROT_B;
`endif

    always_comb begin
        set_mask      = '0;
        set_mask[4:0] = btn_level & ~btn_prev;
`ifdef INPUT_EVENT_ROTARY_EN
        set_mask[5]   = rot_rise & ~rot_b_level;
        set_mask[6]   = rot_rise & rot_b_level;
`endif
    end

    // Isolate the lowest set bit: that is the event currently presented.
    assign lowest   = pending & (~pending + 7'd1);
    assign ack_mask = (iAck && oValid) ? lowest : '0;

    always_comb begin
        code = '0;
        for (int unsigned i = 7; i > 0; i--) begin
            if (pending[i-1]) code = 3'(i);
        end
    end

    // A set on a bit being acked in the same cycle wins and is not an overrun.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= (pending & ~ack_mask) | set_mask;
            if (|(set_mask & pending & ~ack_mask)) overrun <= 1'b1;
        end
    end

    assign oBTN     = btn_level;
    assign oEvent   = code;
    assign oValid   = |pending;
    assign oOverrun = overrun;

endmodule

// File: tb/tb_input_event_unit.sv
// Self-checking bench for input_event_unit: cycle model of debounce/pending rules plus directed literal checks.
// Honours INPUT_EVENT_ROTARY_EN the same way the design does.

module tb_input_event_unit;

    localparam int D = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_LEFT = 1'b0, BTN_RIGHT = 1'b0, BTN_CNTR = 1'b0;
    logic       ROT_A = 1'b0, ROT_B = 1'b0;
    logic       iAck = 1'b0;
    logic [4:0] oBTN;
    logic [2:0] oEvent;
    logic       oValid;
    logic       oOverrun;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    input_event_unit #(
        .DEBOUNCE_CYCLES    (16'd4),
        .ROT_DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .BTN_UP   (BTN_UP),
        .BTN_DOWN (BTN_DOWN),
        .BTN_LEFT (BTN_LEFT),
        .BTN_RIGHT(BTN_RIGHT),
        .BTN_CNTR (BTN_CNTR),
        .ROT_A    (ROT_A),
        .ROT_B    (ROT_B),
        .iAck     (iAck),
        .oBTN     (oBTN),
        .oEvent   (oEvent),
        .oValid   (oValid),
        .oOverrun (oOverrun)
    );

    // Reference model. Channel order: 0..4 buttons, 5 ROT_A, 6 ROT_B.
    logic [6:0] raw_v;
    assign raw_v = {ROT_B, ROT_A, BTN_CNTR, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

    bit [6:0] m_d1, m_d2, m_lvl, m_prev, m_pend, m_set, m_ack;
    bit       m_ovr;
    int       m_run[7];

    function automatic int lowest_idx(bit [6:0] p);
        int r = 7;
        for (int i = 6; i >= 0; i--) if (p[i]) r = i;
        return r;
    endfunction

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_prev = '0; m_pend = '0; m_ovr = 1'b0;
            for (int c = 0; c < 7; c++) m_run[c] = 0;
        end else begin
            m_set = '0;
            for (int k = 0; k < 5; k++) m_set[k] = m_lvl[k] & ~m_prev[k];
`ifdef INPUT_EVENT_ROTARY_EN
            if (m_lvl[5] && !m_prev[5]) begin
                if (m_lvl[6]) m_set[6] = 1'b1;
                else          m_set[5] = 1'b1;
            end
`endif
            m_ack = '0;
            if (iAck && m_pend != 0) m_ack[lowest_idx(m_pend)] = 1'b1;
            if ((m_set & m_pend & ~m_ack) != 0) m_ovr = 1'b1;
            m_pend = (m_pend & ~m_ack) | m_set;
            m_prev = m_lvl;
            // Level flips once the delayed input has disagreed for D consecutive cycles.
            for (int c = 0; c < 7; c++) begin
                if (m_d2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_lvl[c] = ~m_lvl[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = raw_v;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        int lo;
        lo = lowest_idx(m_pend);
        chk("model_oBTN", 32'(oBTN), 32'(m_lvl[4:0]));
        chk("model_oValid", 32'(oValid), 32'(m_pend != 0));
        chk("model_oEvent", 32'(oEvent), (m_pend == 0) ? 32'd0 : 32'(lo + 1));
        chk("model_oOverrun", 32'(oOverrun), 32'(m_ovr));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            check_model();
        end
    endtask

    task automatic ack_one();
        iAck = 1'b1;
        step(1);
        iAck = 1'b0;
    endtask

    initial begin
        step(3);
        chk("reset_oBTN", 32'(oBTN), 32'd0);
        chk("reset_oEvent", 32'(oEvent), 32'd0);
        chk("reset_oValid", 32'(oValid), 32'd0);
        chk("reset_oOverrun", 32'(oOverrun), 32'd0);
        Reset = 1'b1;
        step(2);

        // Single press: level after 6 clocks, event one clock later.
        BTN_UP = 1'b1;
        step(5);
        chk("up_oBTN_before", 32'(oBTN), 32'd0);
        step(1);
        chk("up_oBTN", 32'(oBTN), 32'b00001);
        chk("up_valid_early", 32'(oValid), 32'd0);
        step(1);
        chk("up_valid", 32'(oValid), 32'd1);
        chk("up_event", 32'(oEvent), 32'd1);
        ack_one();
        chk("up_ack_valid", 32'(oValid), 32'd0);
        chk("up_ack_event", 32'(oEvent), 32'd0);
        BTN_UP = 1'b0;
        step(8);
        chk("up_release_valid", 32'(oValid), 32'd0);

        // Glitch of 3 clocks is rejected.
        BTN_LEFT = 1'b1;
        step(3);
        BTN_LEFT = 1'b0;
        step(10);
        chk("glitch_oBTN", 32'(oBTN), 32'd0);
        chk("glitch_valid", 32'(oValid), 32'd0);

        // Simultaneous presses drain in priority order.
        BTN_DOWN = 1'b1;
        BTN_CNTR = 1'b1;
        step(7);
        chk("dual_oBTN", 32'(oBTN), 32'b10010);
        chk("dual_event1", 32'(oEvent), 32'd2);
        ack_one();
        chk("dual_event2", 32'(oEvent), 32'd5);
        ack_one();
        chk("dual_valid_end", 32'(oValid), 32'd0);
        BTN_DOWN = 1'b0;
        BTN_CNTR = 1'b0;
        step(8);

        // Second press while first is pending -> overrun, events merge.
        BTN_RIGHT = 1'b1;
        step(7);
        chk("right_event", 32'(oEvent), 32'd4);
        BTN_RIGHT = 1'b0;
        step(8);
        BTN_RIGHT = 1'b1;
        step(7);
        chk("ovr_event", 32'(oEvent), 32'd4);
        chk("ovr_flag", 32'(oOverrun), 32'd1);
        ack_one();
        chk("ovr_ack_valid", 32'(oValid), 32'd0);
        chk("ovr_sticky", 32'(oOverrun), 32'd1);
        BTN_RIGHT = 1'b0;
        step(8);

`ifdef INPUT_EVENT_ROTARY_EN
        ROT_A = 1'b1;
        step(7);
        chk("rot_cw", 32'(oEvent), 32'd6);
        ack_one();
        ROT_A = 1'b0;
        step(8);
        ROT_B = 1'b1;
        step(8);
        ROT_A = 1'b1;
        step(7);
        chk("rot_ccw", 32'(oEvent), 32'd7);
        ack_one();
        chk("rot_drained", 32'(oValid), 32'd0);
        ROT_A = 1'b0;
        ROT_B = 1'b0;
        step(8);
`else
        ROT_A = 1'b1;
        step(10);
        chk("rot_off_valid", 32'(oValid), 32'd0);
        ROT_A = 1'b0;
        step(10);
        chk("rot_off_valid2", 32'(oValid), 32'd0);
`endif

        // Reset mid-count discards the partial count; held press reappears after release.
        BTN_UP = 1'b1;
        step(3);
        Reset = 1'b0;
        #1;
        chk("rst_oBTN", 32'(oBTN), 32'd0);
        chk("rst_oEvent", 32'(oEvent), 32'd0);
        chk("rst_oValid", 32'(oValid), 32'd0);
        chk("rst_oOverrun", 32'(oOverrun), 32'd0);
        step(2);
        Reset = 1'b1;
        step(6);
        chk("rst_rel_oBTN", 32'(oBTN), 32'b00001);
        chk("rst_rel_valid_early", 32'(oValid), 32'd0);
        step(1);
        chk("rst_rel_event", 32'(oEvent), 32'd1);
        ack_one();
        BTN_UP = 1'b0;
        step(8);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 9) == 0) BTN_UP    = ~BTN_UP;
            if ($urandom_range(0, 9) == 0) BTN_DOWN  = ~BTN_DOWN;
            if ($urandom_range(0, 9) == 0) BTN_LEFT  = ~BTN_LEFT;
            if ($urandom_range(0, 9) == 0) BTN_RIGHT = ~BTN_RIGHT;
            if ($urandom_range(0, 9) == 0) BTN_CNTR  = ~BTN_CNTR;
            if ($urandom_range(0, 7) == 0) ROT_A     = ~ROT_A;
            if ($urandom_range(0, 11) == 0) ROT_B    = ~ROT_B;
            iAck = ($urandom_range(0, 3) == 0);
            if (cyc == 1500) Reset = 1'b0;
            if (cyc == 1503) Reset = 1'b1;
            step(1);
        end
        iAck = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_event_unit.md
INPUT_EVENT_UNIT -- requirements
Module: input_event_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning stable-clock count required to accept a button level change (1 ms at 50 MHz).
REQ-002 SHALL have parameter ROT_DEBOUNCE_CYCLES, default 16'd500, meaning the same stable-clock count for ROT_A/ROT_B.
REQ-003 SHALL have port Clock, input, 1 bit: the single system clock; all state on posedge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CNTR, input, 1 bit each: raw asynchronous push buttons, high = pressed.
REQ-006 SHALL have ports ROT_A, ROT_B, input, 1 bit each: raw quadrature rotary signals.
REQ-007 SHALL have port iAck, input, 1 bit: consumer acknowledges the currently shown event.
REQ-008 SHALL have port oBTN, output, 5 bits: debounced levels {CNTR,RIGHT,LEFT,DOWN,UP}, bit0 = UP.
REQ-009 SHALL have port oEvent, output, 3 bits: code 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 CNTR, 6 CW, 7 CCW; 0 = none.
REQ-010 SHALL have port oValid, output, 1 bit: high while any event is pending.
REQ-011 SHALL have port oOverrun, output, 1 bit: sticky flag set when an event is lost.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized input with its own counter (16 bits), as follows:
- counter clears whenever the synchronized input equals the debounced level;
- otherwise counter increments;
- when counter reaches the limit minus 1, the debounced level toggles and the counter clears.
REQ-014 SHALL make a raw edge held stable appear on oBTN exactly 2+DEBOUNCE_CYCLES clocks later; glitches shorter than DEBOUNCE_CYCLES clocks SHALL never change oBTN.
REQ-015 SHALL set pending-mask bit k (7-bit register, bit k = code k+1) one clock after a debounced rising edge of button k; releases SHALL generate no event.
REQ-016 SHALL decode rotation on each debounced rising edge of ROT_A: debounced ROT_B = 0 sets CW pending, ROT_B = 1 sets CCW pending.
REQ-017 SHALL drive oValid = OR of the pending mask, and oEvent = code of the lowest-numbered pending bit (fixed priority UP highest, CCW lowest), or 0 when nothing is pending.
REQ-018 SHALL clear the pending bit shown on oEvent at the next edge when iAck = 1 and oValid = 1; iAck with oValid = 0 SHALL be ignored.
REQ-019 SHALL set oOverrun when a set arrives for a bit already pending that is not being acknowledged in the same cycle; the pending bit stays 1 (events merge).
REQ-020 SHALL handle a set and an ack of the same bit in the same cycle as follows: set wins, bit stays 1, no overrun.
REQ-021 SHALL accept multiple simultaneous sets in one cycle, all recorded; the consumer SHALL drain them in priority order, one per ack.
REQ-022 SHALL clear oOverrun only by reset.

Reset
REQ-023 SHALL, on Reset low, asynchronously clear all of the following: synchronizers, counters, debounced levels, pending mask, oOverrun.
REQ-024 SHALL therefore output oBTN = 0, oEvent = 0, oValid = 0, oOverrun = 0 during and immediately after reset.
REQ-025 SHALL, on reset asserted mid-debounce, discard the partial count; a button held through reset release SHALL produce one press event 2+DEBOUNCE_CYCLES+1 clocks after release.

Configuration
REQ-026 SHALL use macro INPUT_EVENT_ROTARY_EN for the rotary decode.
REQ-027 SHALL, when INPUT_EVENT_ROTARY_EN is defined, compile in ROT_A/ROT_B synchronizers, debouncers and the decode (REQ-016).
REQ-028 SHALL, when INPUT_EVENT_ROTARY_EN is undefined, omit that logic, ignore ROT_A/ROT_B, hold pending bits 5 and 6 at 0, and never produce codes 6 or 7.

Verification (DEBOUNCE_CYCLES=4, ROT_DEBOUNCE_CYCLES=4)
REQ-029 SHALL verify: BTN_UP rises and is held -> oBTN=5'b00001 after 6 clocks, oValid=1 and oEvent=1 one clock later; iAck for 1 clock -> oValid=0, oEvent=0.
REQ-030 SHALL verify: BTN_LEFT pulse 3 clocks wide -> oBTN stays 0, oValid stays 0.
REQ-031 SHALL verify: BTN_DOWN and BTN_CNTR pressed in the same cycle -> oEvent=2; after ack oEvent=5; after second ack oValid=0.
REQ-032 SHALL verify: BTN_RIGHT pressed, released, pressed again with no ack -> oEvent=4, oOverrun=1; one ack -> oValid=0, oOverrun remains 1.
REQ-033 SHALL verify, with the macro defined: ROT_B=0 then ROT_A rises -> oEvent=6; ROT_B=1 then ROT_A rises -> oEvent=7; with the macro undefined -> oValid stays 0.
REQ-034 SHALL verify: Reset driven low mid-count while BTN_UP is held -> all outputs 0 immediately; after release, oEvent=1 after 7 clocks.
